bit_unpacker: RTL and testbench



---
 rtl/compress_pkg.sv | 23 ++
 rtl/line_position_tracker.sv | 42 ++++
 rtl/bit_unpacker.sv | 76 +++++++
 tb/tb_bit_unpacker.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/compress_pkg.sv
// Shared widths and types for the compressor and decompressor bit-stream paths.
package compress_pkg;

  localparam int unsigned WORD_SIZE  = 64;
  localparam int unsigned CACHE_LINE = 128;
  localparam int unsigned MAX_LEN    = 64;
  localparam int unsigned LEVEL_W    = 8;
  localparam int unsigned LEN_W      = 7;
  localparam int unsigned BUF_W      = 2 * WORD_SIZE;

  typedef logic [LEN_W-1:0]   len_t;
  typedef logic [LEVEL_W-1:0] level_t;

  // Bits actually retired: request clipped to the window width and to what is buffered.
  function automatic level_t clip_len(input len_t len, input level_t level);
    level_t r;
    r = level_t'(len);
    if (r > level_t'(MAX_LEN)) r = level_t'(MAX_LEN);
    if (r > level) r = level;
    return r;
  endfunction

endpackage

// File: rtl/line_position_tracker.sv
// Read-side cache-line accounting: counts consumed bits and pulses once per line boundary.
module line_position_tracker
  import compress_pkg::*;
(
  input  logic   i_clk,
  input  logic   i_reset,
  input  len_t   i_n,
  input  logic   i_flush,
  output logic   o_line_done
);

  level_t             line_cnt_q, line_cnt_d;
  logic               line_done_q, line_done_d;
  logic [LEVEL_W:0]   sum;

  always_comb begin
    sum         = {1'b0, line_cnt_q} + {2'b00, i_n};
    line_cnt_d  = level_t'(sum);
    line_done_d = 1'b0;
    if (sum >= (LEVEL_W+1)'(CACHE_LINE)) begin
      line_cnt_d  = level_t'(sum - (LEVEL_W+1)'(CACHE_LINE));
      line_done_d = 1'b1;
    end
    if (i_flush) begin
      line_cnt_d  = '0;
      line_done_d = 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      line_cnt_q  <= '0;
      line_done_q <= 1'b0;
    end else begin
      line_cnt_q  <= line_cnt_d;
      line_done_q <= line_done_d;
    end
  end

  assign o_line_done = line_done_q;

endmodule

// File: rtl/bit_unpacker.sv
// Holds two packed words and hands the oldest MAX_LEN bits to the decoder,
// retiring a decoder-chosen number of bits per cycle.
module bit_unpacker
  import compress_pkg::*;
(
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic [WORD_SIZE-1:0] i_word,
  input  logic                 i_word_valid,
  output logic                 o_word_ready,
  output logic [MAX_LEN-1:0]   o_window,
  output logic                 o_window_valid,
  input  logic                 i_consume,
  input  logic [LEN_W-1:0]     i_consume_len,
  input  logic                 i_drain,
  input  logic                 i_flush,
  output logic [LEVEL_W-1:0]   o_level,
  output logic                 o_line_done,
  output logic                 o_error
);

  logic [BUF_W-1:0] buf_q, buf_d;
  level_t           level_q, level_d;
  logic             err_q, err_d;
  logic             word_ready, window_valid, consume_ok, accept;
  level_t           n;

  always_comb begin
    word_ready   = (level_q <= level_t'(WORD_SIZE));
    window_valid = (level_q >= level_t'(MAX_LEN)) || (i_drain && (level_q != '0));
    consume_ok   = i_consume && window_valid;
    accept       = i_word_valid && word_ready;
    n            = consume_ok ? clip_len(i_consume_len, level_q) : '0;

    // New word is placed directly above the bits that survive this cycle's consume.
    buf_d   = (buf_q >> n) | (accept ? (BUF_W'(i_word) << (level_q - n)) : '0);
    level_d = level_q - n + (accept ? level_t'(WORD_SIZE) : '0);
    err_d   = err_q
            | (i_consume && !window_valid)
            | (consume_ok && (i_consume_len > len_t'(MAX_LEN)))
            | (consume_ok && ({1'b0, i_consume_len} > level_q));

    if (i_flush) begin
      buf_d   = '0;
      level_d = '0;
      err_d   = err_q;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      buf_q   <= '0;
      level_q <= '0;
      err_q   <= 1'b0;
    end else begin
      buf_q   <= buf_d;
      level_q <= level_d;
      err_q   <= err_d;
    end
  end

  line_position_tracker u_line_position_tracker (
    .i_clk       (i_clk),
    .i_reset     (i_reset),
    .i_n         (len_t'(n)),
    .i_flush     (i_flush),
    .o_line_done (o_line_done)
  );

  assign o_word_ready   = word_ready;
  assign o_window       = buf_q[MAX_LEN-1:0];
  assign o_window_valid = window_valid;
  assign o_level        = level_q;
  assign o_error        = err_q;

endmodule

// File: tb/tb_bit_unpacker.sv
// Self-checking bench for bit_unpacker; reference model keeps buffered bits as a bit queue.
module tb_bit_unpacker;

  logic        i_clk = 1'b0;
  logic        i_reset;
  logic [63:0] i_word;
  logic        i_word_valid;
  logic        o_word_ready;
  logic [63:0] o_window;
  logic        o_window_valid;
  logic        i_consume;
  logic [6:0]  i_consume_len;
  logic        i_drain;
  logic        i_flush;
  logic [7:0]  o_level;
  logic        o_line_done;
  logic        o_error;

  bit_unpacker dut (
    .i_clk          (i_clk),
    .i_reset        (i_reset),
    .i_word         (i_word),
    .i_word_valid   (i_word_valid),
    .o_word_ready   (o_word_ready),
    .o_window       (o_window),
    .o_window_valid (o_window_valid),
    .i_consume      (i_consume),
    .i_consume_len  (i_consume_len),
    .i_drain        (i_drain),
    .i_flush        (i_flush),
    .o_level        (o_level),
    .o_line_done    (o_line_done),
    .o_error        (o_error)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [7:0]  level;
    logic [63:0] win;
    logic        ld;
    logic        err;
  } exp_t;

  exp_t exp_q[$];
  bit   mq[$];
  int   m_line;
  bit   m_ld;
  bit   m_err;
  int   total = 0;
  int   bad   = 0;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] model_window();
    logic [63:0] w;
    w = '0;
    for (int i = 0; i < 64; i++)
      if (i < mq.size()) w[i] = mq[i];
    return w;
  endfunction

  task automatic model_clear(input bit clr_err);
    mq.delete();
    m_line = 0;
    m_ld   = 0;
    if (clr_err) m_err = 0;
  endtask

  // Drive one cycle, predict its result, then compare after the edge.
  task automatic step(input logic vld, input logic [63:0] w, input logic cons,
                      input int len, input logic drn, input logic fl);
    bit   exp_vld, exp_rdy;
    int   n;
    exp_t e;
    exp_t got_e;
    i_word_valid  = vld;
    i_word        = w;
    i_consume     = cons;
    i_consume_len = 7'(len);
    i_drain       = drn;
    i_flush       = fl;
    #1;
    exp_vld = (mq.size() >= 64) || (drn && mq.size() != 0);
    exp_rdy = (mq.size() <= 64);
    check_eq("window_valid", o_window_valid, exp_vld);
    check_eq("word_ready", o_word_ready, exp_rdy);
    if (fl) begin
      model_clear(0);
    end else begin
      n = 0;
      if (cons) begin
        if (!exp_vld) m_err = 1;
        else begin
          if (len > 64) m_err = 1;
          if (len > mq.size()) m_err = 1;
          n = len;
          if (n > 64) n = 64;
          if (n > mq.size()) n = mq.size();
        end
      end
      for (int i = 0; i < n; i++) void'(mq.pop_front());
      m_line += n;
      if (m_line >= 128) begin m_line -= 128; m_ld = 1; end
      else m_ld = 0;
      if (vld && exp_rdy)
        for (int i = 0; i < 64; i++) mq.push_back(w[i]);
    end
    e.level = 8'(mq.size());
    e.win   = model_window();
    e.ld    = m_ld;
    e.err   = m_err;
    exp_q.push_back(e);
    @(posedge i_clk);
    #1;
    if (exp_q.size() == 0) begin
      check_eq("scoreboard_empty", 1, 0);
    end else begin
      got_e = exp_q.pop_front();
      check_eq("level", o_level, got_e.level);
      check_eq("window", o_window, got_e.win);
      check_eq("line_done", o_line_done, got_e.ld);
      check_eq("error", o_error, got_e.err);
    end
  endtask

  task automatic do_reset();
    i_reset       = 1'b0;
    i_word_valid  = 1'b1;
    i_word        = 64'hDEAD_BEEF_0000_FFFF;
    i_consume     = 1'b1;
    i_consume_len = 7'd8;
    i_drain       = 1'b0;
    i_flush       = 1'b0;
    repeat (2) @(posedge i_clk);
    #1;
    check_eq("rst_ready", o_word_ready, 1);
    check_eq("rst_wvalid", o_window_valid, 0);
    check_eq("rst_level", o_level, 0);
    check_eq("rst_line_done", o_line_done, 0);
    check_eq("rst_error", o_error, 0);
    check_eq("rst_window", o_window, 0);
    model_clear(1);
    i_reset      = 1'b1;
    i_word_valid = 1'b0;
    i_consume    = 1'b0;
  endtask

  localparam logic [63:0] W1 = 64'h0123_4567_89AB_CDEF;
  localparam logic [63:0] W2 = 64'hFEDC_BA98_7654_3210;
  localparam logic [63:0] W3 = 64'hA5A5_0F0F_C3C3_9696;

  initial begin
    logic [63:0] win;
    logic [63:0] rw;
    int          rl;
    do_reset();

    // Two words, then a short consume
    step(1, W1, 0, 0, 0, 0);
    step(1, W2, 0, 0, 0, 0);
    check_eq("two_level", o_level, 128);
    check_eq("two_ready", o_word_ready, 0);
    check_eq("two_window", o_window, W1);
    step(0, 0, 1, 4, 0, 0);
    win = o_window;
    check_eq("c4_low", win[59:0], 60'h012_3456_789A_BCDE);
    check_eq("c4_high", win[63:60], 4'h0);
    check_eq("c4_level", o_level, 124);

    // Simultaneous consume and write at level 64
    step(0, 0, 1, 60, 0, 0);
    check_eq("lvl64", o_level, 64);
    step(1, W3, 1, 40, 0, 0);
    check_eq("sim_level", o_level, 88);
    win = o_window;
    check_eq("sim_low", win[23:0], W2[63:40]);
    check_eq("sim_high", win[63:24], W3[39:0]);

    // Line boundary accounting from a clean line position
    step(0, 0, 0, 0, 0, 1);
    step(1, W1, 0, 0, 0, 0);
    step(1, W2, 0, 0, 0, 0);
    step(0, 0, 1, 64, 0, 0);
    check_eq("ld_after_64", o_line_done, 0);
    step(1, W3, 1, 64, 0, 0);
    check_eq("ld_after_128", o_line_done, 1);
    step(1, W1, 1, 30, 0, 0);
    check_eq("ld_pulse_once", o_line_done, 0);
    step(0, 0, 1, 60, 0, 0);
    step(1, W2, 0, 0, 0, 0);
    step(0, 0, 1, 50, 0, 0);
    check_eq("ld_after_140", o_line_done, 1);
    step(0, 0, 0, 0, 0, 0);
    check_eq("ld_drop", o_line_done, 0);

    // Consume with too few bits and no drain
    do_reset();
    step(1, W1, 0, 0, 0, 0);
    step(0, 0, 1, 54, 0, 0);
    check_eq("lvl10", o_level, 10);
    step(0, 0, 1, 5, 0, 0);
    check_eq("nodrain_level", o_level, 10);
    check_eq("nodrain_error", o_error, 1);

    // Oversize length, sticky error, drain, flush
    do_reset();
    step(1, W1, 0, 0, 0, 0);
    step(1, W2, 0, 0, 0, 0);
    step(0, 0, 1, 70, 0, 0);
    check_eq("len70_level", o_level, 64);
    check_eq("len70_error", o_error, 1);
    step(0, 0, 1, 44, 0, 0);
    check_eq("sticky_error", o_error, 1);
    step(0, 0, 1, 20, 1, 0);
    check_eq("drain_level", o_level, 0);
    step(1, W3, 0, 0, 0, 0);
    step(1, W1, 0, 0, 0, 0);
    step(0, 0, 1, 32, 0, 0);
    check_eq("lvl96", o_level, 96);
    step(1, W2, 1, 16, 0, 1);
    check_eq("flush_level", o_level, 0);
    check_eq("flush_error", o_error, 1);
    step(1, W1, 0, 0, 0, 0);
    step(1, W2, 0, 0, 0, 0);
    step(0, 0, 1, 64, 0, 0);
    step(1, W3, 1, 64, 0, 0);
    check_eq("flush_line_reset", o_line_done, 1);

    // Mixed traffic
    do_reset();
    for (int k = 0; k < 200; k++) begin
      rw = {$urandom(), $urandom()};
      rl = (k % 17 == 0) ? int'($urandom_range(65, 127)) : int'($urandom_range(0, 64));
      step(logic'($urandom_range(0, 1)), rw, logic'($urandom_range(0, 1)), rl,
           logic'(($urandom_range(0, 7) == 0)), logic'(($urandom_range(0, 40) == 0)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish, expected completion");
    $fatal(1);
  end

endmodule
